// File: rtl/legv8_flag_branch_unit_pkg.sv
// Shared types for the LEGv8 flag/branch unit: writeback op codes, condition codes,
// FSM states, the NZCV flag struct and the B.cond evaluation function.
package legv8_flag_branch_unit_pkg;

  localparam logic [1:0] OpAdd   = 2'b00;
  localparam logic [1:0] OpSub   = 2'b01;
  localparam logic [1:0] OpLogic = 2'b10;
  localparam logic [1:0] OpRsvd  = 2'b11;

  localparam logic [3:0] CondEq = 4'h0;
  localparam logic [3:0] CondNe = 4'h1;
  localparam logic [3:0] CondHs = 4'h2;
  localparam logic [3:0] CondLo = 4'h3;
  localparam logic [3:0] CondMi = 4'h4;
  localparam logic [3:0] CondPl = 4'h5;
  localparam logic [3:0] CondVs = 4'h6;
  localparam logic [3:0] CondVc = 4'h7;
  localparam logic [3:0] CondHi = 4'h8;
  localparam logic [3:0] CondLs = 4'h9;
  localparam logic [3:0] CondGe = 4'hA;
  localparam logic [3:0] CondLt = 4'hB;
  localparam logic [3:0] CondGt = 4'hC;
  localparam logic [3:0] CondLe = 4'hD;
  localparam logic [3:0] CondAl = 4'hE;
  localparam logic [3:0] CondNv = 4'hF;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  function automatic logic cond_eval(input logic [3:0] cond, input flags_t f);
    logic r;
    case (cond)
      CondEq:  r = f.z;
      CondNe:  r = !f.z;
      CondHs:  r = f.c;
      CondLo:  r = !f.c;
      CondMi:  r = f.n;
      CondPl:  r = !f.n;
      CondVs:  r = f.v;
      CondVc:  r = !f.v;
      CondHi:  r = f.c && !f.z;
      CondLs:  r = !(f.c && !f.z);
      CondGe:  r = (f.n == f.v);
      CondLt:  r = (f.n != f.v);
      CondGt:  r = !f.z && (f.n == f.v);
      CondLe:  r = !(!f.z && (f.n == f.v));
      default: r = 1'b1;  // AL and NV both always execute
    endcase
    return r;
  endfunction

endpackage

// File: rtl/legv8_flag_calc.sv
// Combinational NZCV generation from a retiring flag-setting ALU op.
module legv8_flag_calc
  import legv8_flag_branch_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] result_i,
  output flags_t            flags_o,
  output logic              wr_en_o
);

  logic a_msb, b_msb, r_msb;

  assign a_msb = a_i[DATA_W-1];
  assign b_msb = b_i[DATA_W-1];
  assign r_msb = result_i[DATA_W-1];

  always_comb begin
    flags_o   = '0;
    flags_o.n = r_msb;
    flags_o.z = (result_i == '0);
    wr_en_o   = 1'b1;
    case (op_i)
      OpAdd: begin
        // a + b carries out exactly when a exceeds the headroom ~b
        flags_o.c = (a_i > ~b_i);
        flags_o.v = (a_msb == b_msb) && (r_msb != a_msb);
      end
      OpSub: begin
        flags_o.c = (a_i >= b_i);
        flags_o.v = (a_msb != b_msb) && (r_msb != a_msb);
      end
      OpLogic: begin
        flags_o.c = 1'b0;
        flags_o.v = 1'b0;
      end
      default: wr_en_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/legv8_flag_branch_unit.sv
// Flag register, in-flight flag-writer tracking and B.cond evaluation with a
// writeback bypass so a branch never evaluates stale flags.
module legv8_flag_branch_unit
  import legv8_flag_branch_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned PEND_W = 2
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic              iIssue,
  output logic              oIssueReady,
  input  logic              iWbValid,
  input  logic [1:0]        iWbOp,
  input  logic [DATA_W-1:0] iWbA,
  input  logic [DATA_W-1:0] iWbB,
  input  logic [DATA_W-1:0] iWbResult,
  input  logic              iBrValid,
  input  logic [3:0]        iBrCond,
  output logic              oBrReady,
  output logic              oBrDone,
  output logic              oBrTaken,
  output logic [3:0]        oFlags
);

  localparam logic [PEND_W-1:0] PendMax = '1;
  localparam logic [PEND_W-1:0] PendOne = PEND_W'(1);

  flags_t            flags_q, wb_flags, eff_flags;
  logic              wb_wr;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              issue_acc, flags_current;
  state_e            state_q;
  logic [3:0]        cond_q;
  logic              taken_q;

  legv8_flag_calc #(
    .DATA_W (DATA_W)
  ) u_flag_calc (
    .op_i     (iWbOp),
    .a_i      (iWbA),
    .b_i      (iWbB),
    .result_i (iWbResult),
    .flags_o  (wb_flags),
    .wr_en_o  (wb_wr)
  );

  assign oIssueReady = (pend_q != PendMax);
  assign issue_acc   = iIssue && oIssueReady;

  always_comb begin
    pend_d = pend_q;
    unique case ({issue_acc, iWbValid})
      2'b10:   pend_d = pend_q + PendOne;
      2'b01:   pend_d = (pend_q != '0) ? pend_q - PendOne : pend_q;
      default: pend_d = pend_q;
    endcase
  end

  // The last outstanding writer retiring this cycle makes its flags usable via bypass
  assign flags_current = (pend_q == '0) ||
                         ((pend_q == PendOne) && iWbValid && !issue_acc);
  assign eff_flags     = (iWbValid && wb_wr) ? wb_flags : flags_q;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      flags_q <= '0;
      pend_q  <= '0;
    end else begin
      pend_q <= pend_d;
      if (iWbValid && wb_wr) begin
        flags_q <= wb_flags;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= StIdle;
      cond_q  <= '0;
      taken_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (iBrValid) begin
            cond_q <= iBrCond;
            if (flags_current) begin
              taken_q <= cond_eval(iBrCond, eff_flags);
              state_q <= StResp;
            end else begin
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          if (flags_current) begin
            taken_q <= cond_eval(cond_q, eff_flags);
            state_q <= StResp;
          end
        end
        StResp: begin
          taken_q <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign oBrReady = (state_q == StIdle);
  assign oBrDone  = (state_q == StResp);
  assign oBrTaken = taken_q;
  assign oFlags   = flags_q;

endmodule

// File: tb/tb_legv8_flag_branch_unit.sv
// Self-checking bench: direct flag/ready checks plus a scoreboard of expected branch results.
module tb_legv8_flag_branch_unit;

  localparam int unsigned DATA_W = 64;

  logic              iCLK = 1'b0;
  logic              iRST_n;
  logic              iIssue;
  logic              oIssueReady;
  logic              iWbValid;
  logic [1:0]        iWbOp;
  logic [DATA_W-1:0] iWbA, iWbB, iWbResult;
  logic              iBrValid;
  logic [3:0]        iBrCond;
  logic              oBrReady, oBrDone, oBrTaken;
  logic [3:0]        oFlags;

  int n_chk  = 0;
  int n_fail = 0;
  bit exp_q[$];

  legv8_flag_branch_unit #(
    .DATA_W (DATA_W),
    .PEND_W (2)
  ) dut (
    .iCLK        (iCLK),
    .iRST_n      (iRST_n),
    .iIssue      (iIssue),
    .oIssueReady (oIssueReady),
    .iWbValid    (iWbValid),
    .iWbOp       (iWbOp),
    .iWbA        (iWbA),
    .iWbB        (iWbB),
    .iWbResult   (iWbResult),
    .iBrValid    (iBrValid),
    .iBrCond     (iBrCond),
    .oBrReady    (oBrReady),
    .oBrDone     (oBrDone),
    .oBrTaken    (oBrTaken),
    .oFlags      (oFlags)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later; any response is scoreboarded.
  task automatic tick();
    @(posedge iCLK);
    #1;
    if (oBrDone) begin
      if (exp_q.size() == 0) chk("spurious_done", 1, 0);
      else chk("br_taken", oBrTaken, exp_q.pop_front());
    end
  endtask

  task automatic wb(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                    input logic [63:0] r);
    iWbValid  = 1'b1;
    iWbOp     = op;
    iWbA      = a;
    iWbB      = b;
    iWbResult = r;
    tick();
    iWbValid  = 1'b0;
  endtask

  task automatic issue();
    iIssue = 1'b1;
    tick();
    iIssue = 1'b0;
  endtask

  // Hold the request until the edge on which it is accepted.
  task automatic br(input logic [3:0] cond, input bit exp);
    bit rdy;
    exp_q.push_back(exp);
    iBrValid = 1'b1;
    iBrCond  = cond;
    for (int i = 0; i < 20; i++) begin
      rdy = oBrReady;
      tick();
      if (rdy) break;
      if (i == 19) chk("br_accept_timeout", 1, 0);
    end
    iBrValid = 1'b0;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("resp_timeout", exp_q.size(), 0);
  endtask

  initial begin
    logic [15:0] cond_mask;
    iRST_n = 1'b0; iIssue = 1'b0; iWbValid = 1'b0; iWbOp = 2'b00;
    iWbA = '0; iWbB = '0; iWbResult = '0; iBrValid = 1'b0; iBrCond = 4'h0;
    tick(); tick();
    chk("rst_flags", oFlags, 4'b0000);
    chk("rst_brready", oBrReady, 1);
    chk("rst_issueready", oIssueReady, 1);
    chk("rst_done", oBrDone, 0);
    chk("rst_taken", oBrTaken, 0);
    iRST_n = 1'b1;
    tick();

    // SUB equal operands: Z and no-borrow C
    wb(2'b01, 64'd5, 64'd5, 64'd0);
    chk("flags_sub_eq", oFlags, 4'b0110);
    br(4'h0, 1'b1);
    chk("eq_latency", exp_q.size(), 0);
    wait_empty();

    wb(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
    chk("flags_add_carry", oFlags, 4'b0110);
    wb(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000);
    chk("flags_add_ovf", oFlags, 4'b1001);
    // N=1 Z=0 C=0 V=1 across all sixteen conditions
    cond_mask = 16'hD65A;
    for (int c = 0; c < 16; c++) begin
      br(4'(c), cond_mask[c]);
      wait_empty();
    end

    // Branch waits behind an in-flight writer and resolves through the bypass
    issue();
    br(4'hC, 1'b1);
    chk("wait_brready", oBrReady, 0);
    tick();
    chk("wait_no_done0", oBrDone, 0);
    tick();
    chk("wait_no_done1", oBrDone, 0);
    chk("wait_q_pending", exp_q.size(), 1);
    wb(2'b01, 64'd7, 64'd3, 64'd4);
    chk("bypass_done", exp_q.size(), 0);
    chk("flags_sub_pos", oFlags, 4'b0010);
    wait_empty();

    // Counter saturation at three
    issue(); chk("ir_after1", oIssueReady, 1);
    issue(); chk("ir_after2", oIssueReady, 1);
    issue(); chk("ir_after3", oIssueReady, 0);
    issue(); chk("ir_after4_ignored", oIssueReady, 0);
    wb(2'b00, 64'd1, 64'd1, 64'd2);
    chk("ir_after_wb", oIssueReady, 1);
    chk("flags_add_small", oFlags, 4'b0000);
    iIssue = 1'b1;
    wb(2'b00, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0);
    iIssue = 1'b0;
    chk("ir_issue_wb_same", oIssueReady, 1);
    chk("flags_add_cv", oFlags, 4'b0111);
    issue();
    chk("ir_back_to3", oIssueReady, 0);

    wb(2'b10, 64'd0, 64'd0, 64'h8000_0000_0000_0000);
    chk("flags_logic", oFlags, 4'b1000);
    wb(2'b11, 64'd1, 64'd2, 64'd0);
    chk("flags_rsvd_hold", oFlags, 4'b1000);
    wb(2'b11, 64'd0, 64'd0, 64'd0);
    chk("flags_rsvd_hold2", oFlags, 4'b1000);
    br(4'h0, 1'b0);
    chk("drained_latency", exp_q.size(), 0);
    wait_empty();

    // Retire at zero must not underflow
    wb(2'b11, 64'd0, 64'd0, 64'd0);
    issue(); issue();
    chk("no_underflow", oIssueReady, 1);
    issue();
    chk("ir_full_again", oIssueReady, 0);

    // Reset while waiting drops the request
    iBrValid = 1'b1;
    iBrCond  = 4'h0;
    tick();
    iBrValid = 1'b0;
    chk("pre_rst_wait", oBrReady, 0);
    iRST_n = 1'b0;
    tick();
    chk("mid_rst_flags", oFlags, 4'b0000);
    chk("mid_rst_done", oBrDone, 0);
    chk("mid_rst_taken", oBrTaken, 0);
    chk("mid_rst_brready", oBrReady, 1);
    chk("mid_rst_issueready", oIssueReady, 1);
    iRST_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_no_done", oBrDone, 0);
    end
    chk("post_rst_brready", oBrReady, 1);
    chk("final_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
